// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state type, mode decode helpers and byte geometry.
package spi_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } spi_state_e;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// N-stage input synchronizer with a configurable reset value.
module spi_slave_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI target: MSB-first byte shifting with RX-valid pulses and a TX holding register.
// Define SPI_SLAVE_ERR_FLAGS_EN to add sticky underrun/abort flags with i_err_clr.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE         = 0,
  parameter int unsigned MAX_BYTES_PER_CS = 16,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter logic [7:0]  DEFAULT_TX       = 8'hFF
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [7:0]                          i_TX_Byte,
  input  logic                                i_TX_DV,
  output logic                                o_TX_Ready,
  output logic                                o_RX_DV,
  output logic [7:0]                          o_RX_Byte,
  output logic [$clog2(MAX_BYTES_PER_CS)-1:0] o_RX_Count,
  output logic                                o_done,
  input  logic                                i_SCK,
  input  logic                                i_CSn,
  input  logic                                i_MOSI,
  output logic                                o_MISO,
  output logic                                o_MISO_oe
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  ,
  input  logic                                i_err_clr,
  output logic                                o_underrun,
  output logic                                o_abort
`endif
);

  localparam logic [1:0]  Mode = 2'(SPI_MODE);
  localparam logic        Cpol = cpol(Mode);
  localparam logic        Cpha = cpha(Mode);
  localparam int unsigned CntW = $clog2(MAX_BYTES_PER_CS);
  localparam logic [2:0]  LastBit = 3'(BITS_PER_BYTE - 1);

  logic sck_s, csn_s, mosi_s;
  logic sck_q, csn_q;

  spi_slave_sync #(.Stages(SYNC_STAGES), .ResetVal(Cpol)) u_sync_sck (
    .clk_i  (clk),
    .rst_ni (rstn),
    .d_i    (i_SCK),
    .q_o    (sck_s)
  );

  spi_slave_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_csn (
    .clk_i  (clk),
    .rst_ni (rstn),
    .d_i    (i_CSn),
    .q_o    (csn_s)
  );

  spi_slave_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i  (clk),
    .rst_ni (rstn),
    .d_i    (i_MOSI),
    .q_o    (mosi_s)
  );

  spi_state_e      state_q;
  logic [7:0]      rx_shift_q;
  logic [2:0]      rx_cnt_q;
  logic [6:0]      tx_shift_q;
  logic [2:0]      tx_cnt_q;
  logic            rx_pend_q;
  logic            rx_dv_q;
  logic [7:0]      rx_byte_q;
  logic [CntW-1:0] rx_count_q;
  logic            done_q;
  logic            miso_q;
  logic            oe_q;
  logic [7:0]      hold_q;
  logic            tx_ready_q;

  logic sck_lead, sck_trail, sample_edge, shift_edge, cs_fall, cs_rise;
  logic tx_wr, load_pt;
  logic [7:0] load_byte;

  assign sck_lead    = (sck_q == Cpol) && (sck_s != Cpol);
  assign sck_trail   = (sck_q != Cpol) && (sck_s == Cpol);
  assign sample_edge = Cpha ? sck_trail : sck_lead;
  assign shift_edge  = Cpha ? sck_lead : sck_trail;
  assign cs_fall     = csn_q && !csn_s;
  assign cs_rise     = !csn_q && csn_s;

  assign tx_wr = i_TX_DV && tx_ready_q;

  // CPHA=0 reloads at CS fall and on the 8th shift edge; CPHA=1 on each byte's first shift edge.
  always_comb begin
    load_pt = 1'b0;
    if (state_q == StIdle) begin
      load_pt = cs_fall && !Cpha;
    end else if (!cs_rise && shift_edge) begin
      load_pt = Cpha ? (tx_cnt_q == 3'd0) : (tx_cnt_q == LastBit);
    end
  end

  // Load sees the pre-write holding state, so a same-cycle write lands for the next byte.
  assign load_byte = tx_ready_q ? DEFAULT_TX : hold_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_q      <= Cpol;
      csn_q      <= 1'b1;
      state_q    <= StIdle;
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      rx_pend_q  <= 1'b0;
      rx_dv_q    <= 1'b0;
      rx_byte_q  <= '0;
      rx_count_q <= '0;
      done_q     <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      sck_q     <= sck_s;
      csn_q     <= csn_s;
      done_q    <= 1'b0;
      rx_dv_q   <= 1'b0;
      rx_pend_q <= 1'b0;

      if (rx_pend_q) begin
        rx_dv_q   <= 1'b1;
        rx_byte_q <= rx_shift_q;
      end
      if (rx_dv_q) begin
        rx_count_q <= rx_count_q + CntW'(1);
      end

      if (tx_wr) begin
        hold_q     <= i_TX_Byte;
        tx_ready_q <= 1'b0;
      end
      if (load_pt) begin
        tx_shift_q <= load_byte[6:0];
        miso_q     <= load_byte[7];
        if (!tx_ready_q) begin
          tx_ready_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q    <= StActive;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            rx_count_q <= '0;
            oe_q       <= 1'b1;
          end
        end
        StActive: begin
          if (cs_rise) begin
            state_q  <= StIdle;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            oe_q     <= 1'b0;
            miso_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= {rx_shift_q[6:0], mosi_s};
              rx_cnt_q   <= rx_cnt_q + 3'd1;
              if (rx_cnt_q == LastBit) begin
                rx_pend_q <= 1'b1;
              end
            end
            if (shift_edge) begin
              tx_cnt_q <= tx_cnt_q + 3'd1;
              if (!load_pt) begin
                tx_shift_q <= {tx_shift_q[5:0], 1'b0};
                miso_q     <= tx_shift_q[6];
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_TX_Ready = tx_ready_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Byte  = rx_byte_q;
  assign o_RX_Count = rx_count_q;
  assign o_done     = done_q;
  assign o_MISO     = miso_q;
  assign o_MISO_oe  = oe_q;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic underrun_q, abort_q;
  logic underrun_set, abort_set;

  assign underrun_set = load_pt && tx_ready_q;
  assign abort_set    = (state_q == StActive) && cs_rise && (rx_cnt_q != 3'd0);

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if (underrun_set) begin
        underrun_q <= 1'b1;
      end else if (i_err_clr) begin
        underrun_q <= 1'b0;
      end
      if (abort_set) begin
        abort_q <= 1'b1;
      end else if (i_err_clr) begin
        abort_q <= 1'b0;
      end
    end
  end

  assign o_underrun = underrun_q;
  assign o_abort    = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: one instance per SPI mode, directed host frames, RX monitor.
`timescale 1ns / 1ps
module tb_spi_slave;

  localparam int Half = 25;  // 25 x 20 ns = 500 ns half-period -> 1 MHz SCK

  logic       clk;
  logic       rstn;
  logic [3:0] sck, csn, mosi, miso, oe, tx_dv, tx_ready, rx_dv, done;
  logic [7:0] tx_byte  [4];
  logic [7:0] rx_byte  [4];
  logic [3:0] rx_count [4];
  logic       err_clr;
  logic [3:0] underrun, abort;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
    logic [3:0] idx;
  } rx_exp_t;

  rx_exp_t rx_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [4];
  int exp_done [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(
      .SPI_MODE         (g),
      .MAX_BYTES_PER_CS (16),
      .SYNC_STAGES      (2),
      .DEFAULT_TX       (8'hFF)
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_TX_Byte  (tx_byte[g]),
      .i_TX_DV    (tx_dv[g]),
      .o_TX_Ready (tx_ready[g]),
      .o_RX_DV    (rx_dv[g]),
      .o_RX_Byte  (rx_byte[g]),
      .o_RX_Count (rx_count[g]),
      .o_done     (done[g]),
      .i_SCK      (sck[g]),
      .i_CSn      (csn[g]),
      .i_MOSI     (mosi[g]),
      .o_MISO     (miso[g]),
      .o_MISO_oe  (oe[g])
`ifdef SPI_SLAVE_ERR_FLAGS_EN
      ,
      .i_err_clr  (err_clr),
      .o_underrun (underrun[g]),
      .o_abort    (abort[g])
`endif
    );
  end

`ifndef SPI_SLAVE_ERR_FLAGS_EN
  assign underrun = '0;
  assign abort    = '0;
`endif

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    rx_exp_t e;
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m]) begin
        if (rx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: mode %0d got %0h expected no byte", m, rx_byte[m]);
        end else begin
          e = rx_q.pop_front();
          check("rx_mode", 32'(m), 32'(e.mode));
          check("rx_byte", 32'(rx_byte[m]), 32'(e.data));
          check("rx_count", 32'(rx_count[m]), 32'(e.idx));
        end
      end
      if (done[m]) done_cnt[m]++;
    end
  end

  task automatic push_rx(input logic [1:0] m, input logic [7:0] d, input logic [3:0] i);
    rx_exp_t e;
    e.mode = m;
    e.data = d;
    e.idx  = i;
    rx_q.push_back(e);
  endtask

  task automatic queue_tx(input logic [1:0] m, input logic [7:0] b);
    int n = 0;
    while (!tx_ready[m] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready[m]) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_ready_timeout: mode %0d got 0 expected 1", m);
    end else begin
      tx_byte[m] = b;
      tx_dv[m]   = 1'b1;
      @(negedge clk);
      tx_dv[m]   = 1'b0;
    end
  endtask

  // Host side of one CS frame; bits are right-aligned, MSB sent first.
  task automatic spi_xfer(input logic [1:0] m, input int nbits, input logic [23:0] mo,
                          output logic [23:0] mi);
    logic cp, ch;
    cp = m[1];
    ch = m[0];
    mi = '0;
    csn[m] = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!ch) begin
        mosi[m] = mo[nbits-1-i];
        repeat (Half) @(negedge clk);
        sck[m] = ~cp;
        mi[nbits-1-i] = miso[m];
        repeat (Half) @(negedge clk);
        sck[m] = cp;
      end else begin
        sck[m]  = ~cp;
        mosi[m] = mo[nbits-1-i];
        repeat (Half) @(negedge clk);
        sck[m] = cp;
        mi[nbits-1-i] = miso[m];
        repeat (Half) @(negedge clk);
      end
    end
    repeat (Half) @(negedge clk);
    csn[m] = 1'b1;
    repeat (10) @(negedge clk);
    exp_done[m]++;
  endtask

  initial begin
    logic [23:0] rd;
    sck     = 4'b1100;
    csn     = 4'hF;
    mosi    = '0;
    tx_dv   = '0;
    err_clr = 1'b0;
    for (int m = 0; m < 4; m++) begin
      tx_byte[m]  = '0;
      done_cnt[m] = 0;
      exp_done[m] = 0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_tx_ready", 32'(tx_ready), 32'hF);
    check("reset_oe", 32'(oe), 32'h0);
    check("reset_miso", 32'(miso), 32'h0);
    check("reset_rx_dv_done", 32'({rx_dv, done}), 32'h0);
    check("reset_rx_byte", 32'({rx_byte[0], rx_byte[3]}), 32'h0);
    check("reset_rx_count", 32'({rx_count[1], rx_count[2]}), 32'h0);

    // Mode 0 single byte.
    queue_tx(2'd0, 8'h3C);
    check("tx_ready_after_write", 32'(tx_ready[0]), 32'h0);
    push_rx(2'd0, 8'hA5, 4'd0);
    spi_xfer(2'd0, 8, 24'hA5, rd);
    check("m0_miso", rd, 32'h3C);
    check("m0_rx_drained", 32'(rx_q.size()), 32'h0);
    check("m0_done", 32'(done_cnt[0]), 32'(exp_done[0]));
    check("m0_oe_idle", 32'(oe[0]), 32'h0);

    // Modes 1..3, three-byte frames with TX refilled before each load.
    for (int k = 1; k < 4; k++) begin
      logic [1:0] m;
      m = 2'(k);
      queue_tx(m, 8'hC3);
      push_rx(m, 8'h01, 4'd0);
      push_rx(m, 8'h80, 4'd1);
      push_rx(m, 8'hFF, 4'd2);
      fork
        spi_xfer(m, 24, 24'h0180FF, rd);
        begin
          queue_tx(m, 8'h5A);
          queue_tx(m, 8'h96);
        end
      join
      check("m123_miso", rd, 32'hC35A96);
      check("m123_rx_drained", 32'(rx_q.size()), 32'h0);
      check("m123_done", 32'(done_cnt[k]), 32'(exp_done[k]));
    end

    // Underrun: nothing queued.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check("underrun_cleared", 32'(underrun[0]), 32'h0);
`endif
    push_rx(2'd0, 8'h12, 4'd0);
    push_rx(2'd0, 8'h34, 4'd1);
    spi_xfer(2'd0, 16, 24'h1234, rd);
    check("underrun_miso", rd, 32'hFFFF);
    check("underrun_rx_drained", 32'(rx_q.size()), 32'h0);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check("underrun_flag", 32'(underrun[0]), 32'h1);
`endif

    // Abort after 5 bits, then a clean frame.
    spi_xfer(2'd1, 5, 24'h1F, rd);
    check("abort_done", 32'(done_cnt[1]), 32'(exp_done[1]));
    check("abort_no_rx", 32'(rx_q.size()), 32'h0);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check("abort_flag", 32'(abort[1]), 32'h1);
`endif
    push_rx(2'd1, 8'h5A, 4'd0);
    spi_xfer(2'd1, 8, 24'h5A, rd);
    check("after_abort_rx_drained", 32'(rx_q.size()), 32'h0);

    // Write while holding register full is ignored.
    queue_tx(2'd2, 8'h22);
    tx_byte[2] = 8'h11;
    tx_dv[2]   = 1'b1;
    @(negedge clk);
    tx_dv[2]   = 1'b0;
    check("ignored_wr_ready", 32'(tx_ready[2]), 32'h0);
    push_rx(2'd2, 8'h77, 4'd0);
    spi_xfer(2'd2, 8, 24'h77, rd);
    check("ignored_wr_miso", rd, 32'h22);
    check("ignored_wr_ready_after", 32'(tx_ready[2]), 32'h1);

    // Reset mid-byte in mode 3.
    csn[3] = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sck[3]  = 1'b0;
      mosi[3] = 1'b1;
      repeat (Half) @(negedge clk);
      sck[3] = 1'b1;
      repeat (Half) @(negedge clk);
    end
    queue_tx(2'd3, 8'h99);
    check("pre_reset_oe", 32'(oe[3]), 32'h1);
    check("pre_reset_ready", 32'(tx_ready[3]), 32'h0);
    rstn = 1'b0;
    #1;
    check("rst_oe", 32'(oe[3]), 32'h0);
    check("rst_miso", 32'(miso[3]), 32'h0);
    check("rst_ready", 32'(tx_ready[3]), 32'h1);
    check("rst_rx_byte", 32'(rx_byte[3]), 32'h0);
    check("rst_rx_count", 32'(rx_count[3]), 32'h0);
    @(negedge clk);
    csn[3] = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    push_rx(2'd3, 8'hC3, 4'd0);
    spi_xfer(2'd3, 8, 24'hC3, rd);
    check("post_reset_miso", rd, 32'hFF);
    check("post_reset_rx_drained", 32'(rx_q.size()), 32'h0);
    check("post_reset_done", 32'(done_cnt[3]), 32'(exp_done[3]));

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (peripheral) serving the same link that spi_master drives as initiator.
- Oversamples external i_SCK/i_CSn/i_MOSI on the system clock; synchronizes them and detects SCK edges.
- Shifts bytes MSB-first in both directions and exposes byte-level RX-valid pulses and a TX ready/valid holding register.
- Used to attach the SoC to an external SPI host, such as a debug or boot controller.

Parameters:
- SPI_MODE, 0: 0-3; CPOL = mode[1], CPHA = mode[0], same encoding as spi_master.
- MAX_BYTES_PER_CS, 16: sizes o_RX_Count.
- SYNC_STAGES, 2: flops per input synchronizer, >= 2.
- DEFAULT_TX, 8'hFF: byte shifted out when no TX byte is queued at a load point.

Ports:
- clk  in  1  system clock; must be >= 8x i_SCK frequency.
- rstn  in  1  asynchronous, active-low reset.
- i_TX_Byte  in  8  byte to return on MISO.
- i_TX_DV  in  1  write strobe; accepted only when o_TX_Ready=1.
- o_TX_Ready  out  1  holding register empty.
- o_RX_DV  out  1  one-cycle pulse: o_RX_Byte is valid.
- o_RX_Byte  out  8  last complete received byte.
- o_RX_Count  out  $clog2(MAX_BYTES_PER_CS)  index of the byte in o_RX_Byte within the current CS frame.
- o_done  out  1  one-cycle pulse when CS deasserts.
- i_SCK  in  1  async SPI clock.
- i_CSn  in  1  async chip select.
- i_MOSI  in  1  async data in.
- o_MISO  out  1  data out.
- o_MISO_oe  out  1  MISO output enable; pad tri-states when 0.

Behaviour:
- Reset values (async on rstn low): all outputs 0 except o_TX_Ready=1; sync chains: SCK=CPOL, CSn=1, MOSI=0; state IDLE; holding register empty.
- Sync: each input passes through SYNC_STAGES flops. Edges are derived from the last stage vs one extra delayed flop.
  - Leading edge: SCK leaves CPOL. Trailing edge: SCK returns to CPOL.
  - Sample edge: leading if CPHA=0, else trailing. Shift edge: the other one.
- FSM, IDLE -> ACTIVE:
  - Transition on synced CSn falling.
  - Clears RX/TX bit counters and o_RX_Count.
  - Asserts o_MISO_oe.
  - CPHA=0 only: performs a load point, driving o_MISO = byte[7].
  - Host must leave >= SYNC_STAGES+3 clk between CSn fall and first SCK edge.
- FSM, ACTIVE:
  - Sample edge: rx_shift <= {rx_shift[6:0], MOSI}; rx bit count +1.
    - On the 8th bit, the next clk sets o_RX_Byte = completed byte and pulses o_RX_DV.
    - o_RX_Count advances the cycle after the pulse, wrapping modulo 2^width.
  - Shift edge: o_MISO <= next tx_shift bit.
  - Load points:
    - CPHA=0: CS fall, and every 8th shift edge.
    - CPHA=1: the 1st shift edge of each byte.
  - At a load point: if the holding register is full, move it into tx_shift, present bit 7, set o_TX_Ready=1. Otherwise load DEFAULT_TX (underrun).
- FSM, ACTIVE -> IDLE:
  - Transition on synced CSn rising, including mid-byte.
  - Partial RX byte discarded, no o_RX_DV.
  - Bit counters cleared; o_MISO_oe=0, o_MISO=0.
  - o_done pulses for 1 cycle.
  - Holding register contents retained.
- Holding register:
  - i_TX_DV while o_TX_Ready=1 writes it; o_TX_Ready falls the next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored.
  - i_TX_DV in the same cycle as a load point: the load sees the pre-write state, and the write lands for the next byte.
- RX has no backpressure; consumer must take o_RX_Byte within 8 SCK periods.

Optional Feature:
- SPI_SLAVE_ERR_FLAGS_EN defined: adds ports i_err_clr (in, 1), o_underrun (out, 1) and o_abort (out, 1).
  - o_underrun: sticky; set when DEFAULT_TX is loaded.
  - o_abort: sticky; set on CS rise with rx bit count != 0.
  - i_err_clr clears both; a same-cycle set wins over clear.
- Undefined: ports absent; no other behaviour change.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, ACTIVE}
  - mode-decode functions cpol(mode)/cpha(mode), shared with spi_master
  - constant BITS_PER_BYTE=8
- Sub-module spi_slave_sync: parameterized N-stage synchronizer with reset value parameter, instantiated three times.

Test Plan:
- Mode 0, 1 MHz SCK, 50 MHz clk; host sends 8'hA5 with TX queued 8'h3C -> o_RX_DV once, o_RX_Byte=8'hA5, o_RX_Count=0; host reads 8'h3C; o_done pulses after CS rise.
- Modes 1, 2, 3, 3-byte frame 8'h01,8'h80,8'hFF, TX queued before each load -> three RX_DV with counts 0, 1, 2, bytes match; host reads queued bytes.
- No TX queued, 2-byte frame -> host reads 8'hFF,8'hFF; o_underrun=1 with macro.
- CS rises after 5 bits -> no o_RX_DV, o_done pulse, o_abort=1; next frame 8'h5A received correctly.
- i_TX_DV pulsed while o_TX_Ready=0 with 8'h11 -> ignored; previously queued 8'h22 transmitted.
- rstn asserted mid-byte -> outputs immediately at reset values, o_TX_Ready=1; post-reset frame 8'hC3 received correctly.
